// File: rtl/mem_stage.sv
// Memory pipeline stage: issues load/store requests to data memory, aligns and
// extends load data, and stalls exe while an access is in flight.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        rd_we_i,
    output logic        stall_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    output logic        req_we_o,
    output logic [3:0]  req_wstrb_o,
    output logic [31:0] req_wdata_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic [31:0] wb_data_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

    localparam int unsigned      LIMIT_INT  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(LIMIT_INT);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        rdWe_q, rdWe_d;
    logic        store_q, store_d;

    logic        wbValid_q, wbValid_d;
    logic [4:0]  wbRd_q, wbRd_d;
    logic        wbWe_q, wbWe_d;
    logic [31:0] wbData_q, wbData_d;
    logic        misaligned_q, misaligned_d;
    logic        busErr_q, busErr_d;

    logic        misalignedIn;
    logic        handshake;
    logic        timeoutHit;
    logic [1:0]  offset;
    logic [31:0] shifted;
    logic [31:0] loadData;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    assign offset       = addr_q[1:0];
    assign misalignedIn = ((mem_size_i == 2'b01) && addr_i[0]) ||
                          (mem_size_i[1] && (addr_i[1:0] != 2'b00));
    assign handshake    = req_valid_o && req_ready_i;
    assign timeoutHit   = TIMEOUT_EN && (cnt_q == LIMIT);

    // Load data is shifted down to the addressed lane, then sign- or zero-extended.
    assign shifted = rsp_rdata_i >> {offset, 3'b000};

    always_comb begin
        loadData = rsp_rdata_i;
        case (size_q)
            2'b00:   loadData = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   loadData = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: loadData = rsp_rdata_i;
        endcase
    end

    always_comb begin
        wstrb = 4'b1111;
        wdata = rs2_q;
        case (size_q)
            2'b00: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{rs2_q[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{rs2_q[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = rs2_q;
            end
        endcase
    end

    assign stall_o     = (state_q != IDLE);
    assign req_valid_o = (state_q == REQ);
    assign req_addr_o  = req_valid_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign req_we_o    = req_valid_o & store_q;
    assign req_wstrb_o = req_valid_o ? wstrb : 4'h0;
    assign req_wdata_o = req_valid_o ? wdata : 32'h0;

    assign wb_valid_o   = wbValid_q;
    assign wb_rd_o      = wbRd_q;
    assign wb_we_o      = wbWe_q;
    assign wb_data_o    = wbData_q;
    assign misaligned_o = misaligned_q;
    assign bus_err_o    = busErr_q;

    // A completion in the timeout cycle wins over the abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rdWe_d       = rdWe_q;
        store_d      = store_q;
        wbValid_d    = 1'b0;
        wbRd_d       = 5'd0;
        wbWe_d       = 1'b0;
        wbData_d     = 32'h0;
        misaligned_d = 1'b0;
        busErr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    size_d     = mem_size_i;
                    unsigned_d = mem_unsigned_i;
                    addr_d     = addr_i;
                    rs2_d      = data_rs2_i;
                    rd_d       = rd_i;
                    rdWe_d     = rd_we_i;
                    store_d    = is_store_i;
                    if (!is_load_i && !is_store_i) begin
                        wbValid_d = 1'b1;
                        wbRd_d    = rd_i;
                        wbWe_d    = rd_we_i && (rd_i != 5'd0);
                        wbData_d  = addr_i;
                    end else if (misalignedIn) begin
                        wbValid_d    = 1'b1;
                        wbRd_d       = rd_i;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (handshake) begin
                    if (store_q) begin
                        state_d   = IDLE;
                        wbValid_d = 1'b1;
                        wbRd_d    = rd_q;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end else if (timeoutHit) begin
                    state_d   = IDLE;
                    wbValid_d = 1'b1;
                    wbRd_d    = rd_q;
                    busErr_d  = 1'b1;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (rsp_valid_i) begin
                    state_d   = IDLE;
                    wbValid_d = 1'b1;
                    wbRd_d    = rd_q;
                    wbWe_d    = rdWe_q && (rd_q != 5'd0);
                    wbData_d  = loadData;
                end else if (timeoutHit) begin
                    state_d   = IDLE;
                    wbValid_d = 1'b1;
                    wbRd_d    = rd_q;
                    busErr_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'h0;
            rs2_q        <= 32'h0;
            rd_q         <= 5'd0;
            rdWe_q       <= 1'b0;
            store_q      <= 1'b0;
            wbValid_q    <= 1'b0;
            wbRd_q       <= 5'd0;
            wbWe_q       <= 1'b0;
            wbData_q     <= 32'h0;
            misaligned_q <= 1'b0;
            busErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rdWe_q       <= rdWe_d;
            store_q      <= store_d;
            wbValid_q    <= wbValid_d;
            wbRd_q       <= wbRd_d;
            wbWe_q       <= wbWe_d;
            wbData_q     <= wbData_d;
            misaligned_q <= misaligned_d;
            busErr_q     <= busErr_d;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage of the tartaruga core. Sits between exe and writeback, consuming the exe-to-mem handoff.
- Issues load/store requests to the data memory over a valid/ready request channel with a separate response channel.
- Aligns and extends load data, and back-pressures exe through `stall_o` while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles an access may spend in REQ+WAIT_RSP before abort; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  instruction from exe is valid
- is_load_i  in  1  instruction is a load
- is_store_i  in  1  instruction is a store
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_i  in  1  zero-extend load (LBU/LHU)
- addr_i  in  32  ALU result: memory address, or rd data for non-memory ops
- data_rs2_i  in  32  store data
- rd_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- stall_o  out  1  exe must hold its outputs
- req_valid_o  out  1  data memory request valid
- req_ready_i  in  1  data memory accepts request
- req_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- req_we_o  out  1  1 = store
- req_wstrb_o  out  4  byte enables
- req_wdata_o  out  32  lane-replicated store data
- rsp_valid_i  in  1  load data valid
- rsp_rdata_i  in  32  load word
- wb_valid_o  out  1  one-cycle pulse: result to writeback
- wb_rd_o  out  5  destination register
- wb_we_o  out  1  register write enable
- wb_data_o  out  32  result data
- misaligned_o  out  1  qualifies wb_valid_o: misaligned access, no write
- bus_err_o  out  1  qualifies wb_valid_o: timeout abort, no write

Behaviour:
- Reset: state IDLE, counter 0, captured instruction cleared. All outputs 0 (stall_o, req_*, wb_*, misaligned_o, bus_err_o).
- FSM states: IDLE, REQ, WAIT_RSP.
- stall_o = (state != IDLE), driven from a registered state. Exe holds its inputs stable while stall_o=1.
- Capture: in IDLE with valid_i=1, all inputs are captured into internal registers.
- Non-memory op (valid_i, !is_load_i, !is_store_i) in IDLE:
  - Next cycle: wb_valid_o=1, wb_data_o=addr_i, wb_rd_o=rd_i.
  - wb_we_o = rd_we_i && (rd_i != 0).
  - Latency 1; state stays IDLE.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - No memory request is issued.
  - Next cycle: wb_valid_o=1, misaligned_o=1, wb_we_o=0; state stays IDLE.
- Aligned load/store in IDLE: go to REQ next cycle and clear the counter.
- REQ:
  - req_valid_o=1; req_addr/we/wstrb/wdata are stable until the handshake.
  - Handshake = req_valid_o && req_ready_i.
  - Store handshake: to IDLE; next cycle wb_valid_o=1, wb_we_o=0.
  - Load handshake: to WAIT_RSP; req_valid_o drops next cycle.
- WAIT_RSP: on rsp_valid_i, to IDLE. Next cycle wb_valid_o=1 with extracted data, wb_we_o = rd_we && rd!=0.
- Load extraction, byte offset o = addr[1:0]:
  - byte = rdata[8o+7:8o]; half = rdata[8o+15:8o] (o in {0,2}); word = rdata.
  - Sign-extend unless mem_unsigned.
- Store formatting:
  - byte: wdata = {4{rs2[7:0]}}, wstrb = 0001 << o.
  - half: wdata = {2{rs2[15:0]}}, wstrb = 0011 << o.
  - word: wdata = rs2, wstrb = 1111.
- Timeout:
  - Counter increments each cycle in REQ or WAIT_RSP.
  - If TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 without completion: go to IDLE; next cycle wb_valid_o=1, bus_err_o=1, wb_we_o=0.
  - Completion in the same cycle as the limit takes priority over timeout.
  - rsp_valid_i received in IDLE or REQ is ignored (late or stray responses).
- After any completion, stall_o is still 1 in the completion cycle and drops the cycle after. This gives one bubble per memory op.
- wb_valid_o, misaligned_o, bus_err_o are single-cycle pulses and 0 otherwise.
- Reset mid-access returns to IDLE immediately with all outputs 0; the outstanding request is abandoned.

Test Plan:
- Non-memory op: addr_i=0x1234, rd=5, we=1 -> one cycle later wb_valid=1, wb_data=0x1234, wb_we=1, stall_o never asserted.
- LB at 0x103, rdata=0x80AABBCC (req_ready=1, rsp 2 cycles later) -> req_addr=0x100, req_we=0, wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, rs2=0xDEADBEEF, req_ready low for 3 cycles -> req_valid held 4 cycles with stable wstrb=1100, wdata=0xBEEFBEEF. wb_valid with wb_we=0 one cycle after the handshake; stall_o high throughout, low one cycle later.
- LW at 0x301 -> no req_valid; wb_valid=1, misaligned_o=1, wb_we=0 next cycle.
- TIMEOUT_CYCLES=4, LW with rsp_valid never asserted -> bus_err_o pulse after 4 cycles in REQ/WAIT_RSP, state back to IDLE. A later stray rsp_valid produces no wb_valid.
- Assert rstn_i low while in WAIT_RSP -> all outputs 0 immediately. After release, a new non-memory op completes normally.
